// File: rtl/cpu_seq_ctrl_pkg.sv
// cpu_seq_ctrl_pkg: state encoding and opcode constants shared by the sequencer and execute decode
package cpu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_SW   = 6'd24;
    localparam logic [5:0] OP_SH   = 6'd26;
    localparam logic [5:0] OP_SB   = 6'd28;
    localparam logic [5:0] OP_HALT = 6'h3f;

    function automatic logic is_store(input logic [5:0] op);
        return op == OP_SW || op == OP_SH || op == OP_SB;
    endfunction

endpackage

// File: rtl/seq_counter32.sv
// seq_counter32: 32-bit wrapping event counter with enable and synchronous clear
module seq_counter32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] q
);

    // count enabled events; clear and reset both return to zero
    always_ff @(posedge clk)
        if (rst || clr) q <= 32'd0;
        else if (en) q <= q + 32'd1;

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer owning PC, IR and retired count
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [5:0]  HALT_OP  = OP_HALT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic        step_i,
    input  logic        stop_i,
    input  logic [31:0] imem_data_i,
    input  logic [31:0] nextpc_i,
    input  logic [4:0]  wra_i,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic        rf_we_o,
    output logic        dm_we_o,
    output logic        busy_o,
    output logic        halted_o,
    output logic [31:0] instret_o
);

    state_t state, state_nx;
    logic   cont, stop_pend, stop_nx;

    assign busy_o   = state == S_FETCH || state == S_DECODE || state == S_EXEC || state == S_WB;
    assign halted_o = state == S_HALT;
    assign rf_we_o  = state == S_WB && wra_i != 5'd0;
    assign dm_we_o  = state == S_EXEC && is_store(ir_o[31:26]);

    // next state and stop-pending flag; the flag drops whenever the core leaves the busy states
    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:   state_nx = (run_i || step_i) ? S_FETCH : S_IDLE;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = ir_o[31:26] == HALT_OP ? S_HALT : S_EXEC;
            S_EXEC:   state_nx = S_WB;
            S_WB:     state_nx = (cont && !stop_pend && !stop_i) ? S_FETCH : S_IDLE;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
        stop_nx = (state_nx == S_IDLE || state_nx == S_HALT) ? 1'b0 : stop_pend | (busy_o & stop_i);
    end

    // state register, mode capture, instruction latch and PC update
    always_ff @(posedge clk)
        if (rst) begin
            state     <= S_IDLE;
            pc_o      <= RESET_PC;
            ir_o      <= 32'd0;
            cont      <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            stop_pend <= stop_nx;
            if (state == S_IDLE) cont <= run_i;
            if (state == S_FETCH) ir_o <= imem_data_i;
            if (state == S_WB) pc_o <= nextpc_i;
        end

    seq_counter32 u_instret (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (state == S_WB),
        .q   (instret_o)
    );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: randomized and directed check of cpu_seq_ctrl against an instruction-level model
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1, run_i = 1'b0, step_i = 1'b0, stop_i = 1'b0;
    logic [31:0] imem_data_i, nextpc_i, pc_o, ir_o, instret_o;
    logic [4:0]  wra_i;
    logic        rf_we_o, dm_we_o, busy_o, halted_o;

    logic [31:0] imem [32];
    logic [31:0] dmem [16];
    logic [31:0] regf [32];

    int n_chk = 0, n_fail = 0;

    // model: mode 0 idle, 1 running an instruction (slot = cycle within it), 2 halted
    int          m_mode = 0, m_slot = 0;
    bit          m_cont = 0, m_pend = 0;
    logic [31:0] m_pc = 0, m_ir = 0, m_cnt = 0;

    always #5 clk = ~clk;

    cpu_seq_ctrl dut (
        .clk(clk), .rst(rst), .run_i(run_i), .step_i(step_i), .stop_i(stop_i),
        .imem_data_i(imem_data_i), .nextpc_i(nextpc_i), .wra_i(wra_i),
        .pc_o(pc_o), .ir_o(ir_o), .rf_we_o(rf_we_o), .dm_we_o(dm_we_o),
        .busy_o(busy_o), .halted_o(halted_o), .instret_o(instret_o)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [15:0] imm);
        return {op, 5'd0, rd, imm};
    endfunction

    function automatic bit is_st(input logic [31:0] ir);
        return ir[31:26] == 6'd24 || ir[31:26] == 6'd26 || ir[31:26] == 6'd28;
    endfunction

    function automatic logic [4:0] dp_wra(input logic [31:0] ir);
        return (is_st(ir) || ir[31:26] == 6'd2 || ir[31:26] == 6'd3 || ir[31:26] == 6'h3f) ? 5'd0 : ir[20:16];
    endfunction

    function automatic logic [31:0] dp_npc(input logic [31:0] pc, input logic [31:0] ir);
        return ir[31:26] == 6'd2 ? {16'd0, ir[15:0]} : ir[31:26] == 6'd3 ? 32'hffffffff : pc + 32'd1;
    endfunction

    assign imem_data_i = imem[pc_o[4:0]];
    assign wra_i       = dp_wra(ir_o);
    assign nextpc_i    = dp_npc(pc_o, ir_o);

    always @(posedge clk) begin
        if (dm_we_o) dmem[ir_o[3:0]] <= {16'd0, ir_o[15:0]};
        if (rf_we_o) regf[wra_i] <= ir_o[31:26] == 6'd16 ? dmem[ir_o[3:0]] : pc_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_pc = 32'd0; m_ir = 32'd0; m_cnt = 32'd0; m_pend = 0; m_cont = 0;
        end else if (m_mode == 0) begin
            if (run_i || step_i) begin m_mode = 1; m_slot = 0; m_cont = run_i; end
        end else if (m_mode == 1) begin
            if (stop_i) m_pend = 1;
            if (m_slot == 0) begin
                m_ir = imem[m_pc[4:0]]; m_slot = 1;
            end else if (m_slot == 1) begin
                if (m_ir[31:26] == 6'h3f) begin m_mode = 2; m_pend = 0; end
                else m_slot = 2;
            end else if (m_slot == 2) begin
                m_slot = 3;
            end else begin
                m_pc = dp_npc(m_pc, m_ir);
                m_cnt = m_cnt + 32'd1;
                if (m_cont && !m_pend) m_slot = 0;
                else begin m_mode = 0; m_pend = 0; end
            end
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            @(negedge clk);
            chk("pc", pc_o, m_pc);
            chk("ir", ir_o, m_ir);
            chk("instret", instret_o, m_cnt);
            chk("busy", 32'(busy_o), 32'(m_mode == 1));
            chk("halted", 32'(halted_o), 32'(m_mode == 2));
            chk("rf_we", 32'(rf_we_o), 32'(m_mode == 1 && m_slot == 3 && dp_wra(m_ir) != 5'd0));
            chk("dm_we", 32'(dm_we_o), 32'(m_mode == 1 && m_slot == 2 && is_st(m_ir)));
        end
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 32; i++) imem[i] = w;
    endtask

    task automatic reset2();
        rst = 1; run_i = 0; step_i = 0; stop_i = 0;
        cyc(2);
        rst = 0;
    endtask

    task automatic pulse_run();
        run_i = 1; cyc(); run_i = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
        for (int i = 0; i < 32; i++) regf[i] = 32'd0;
        fill(mk(6'd1, 5'd1, 16'd0));

        reset2();
        cyc(10);
        chk("idle_pc", pc_o, 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_instret", instret_o, 32'd0);

        imem[0] = mk(6'd1, 5'd3, 16'd0);
        imem[1] = mk(6'd24, 5'd0, 16'hbee5);
        imem[2] = mk(6'd16, 5'd4, 16'h0005);
        imem[3] = mk(6'h3f, 5'd0, 16'd0);
        reset2();
        pulse_run();
        cyc(4);
        chk("alu_pc", pc_o, 32'd1);
        chk("alu_instret", instret_o, 32'd1);
        chk("alu_next_fetch", 32'(busy_o), 32'd1);
        cyc(8);
        chk("ld_instret", instret_o, 32'd3);
        chk("ld_value", regf[4], 32'h0000bee5);
        cyc(2);
        chk("a_halted", 32'(halted_o), 32'd1);

        fill(mk(6'd1, 5'd2, 16'd0));
        imem[2] = mk(6'h3f, 5'd0, 16'd0);
        reset2();
        pulse_run();
        cyc(10);
        chk("halt_flag", 32'(halted_o), 32'd1);
        chk("halt_pc", pc_o, 32'd2);
        chk("halt_instret", instret_o, 32'd2);
        run_i = 1; step_i = 1; cyc(3); run_i = 0; step_i = 0;
        chk("halt_sticky", 32'(halted_o), 32'd1);

        fill(mk(6'd1, 5'd7, 16'd0));
        reset2();
        pulse_run();
        cyc(10);
        stop_i = 1; cyc(); stop_i = 0;
        cyc();
        chk("stop_busy", 32'(busy_o), 32'd0);
        chk("stop_instret", instret_o, 32'd3);
        step_i = 1; cyc(); step_i = 0;
        cyc(4);
        chk("step_busy", 32'(busy_o), 32'd0);
        chk("step_instret", instret_o, 32'd4);
        run_i = 1; step_i = 1; cyc(); run_i = 0; step_i = 0;
        cyc(8);
        chk("runstep_busy", 32'(busy_o), 32'd1);
        chk("runstep_instret", instret_o, 32'd6);
        cyc(2);
        rst = 1; cyc(); rst = 0;
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rfwe", 32'(rf_we_o), 32'd0);
        chk("rst_instret", instret_o, 32'd0);
        cyc(3);

        fill(mk(6'd1, 5'd1, 16'd0));
        imem[0]  = mk(6'd2, 5'd0, 16'h0010);
        imem[16] = mk(6'd3, 5'd0, 16'd0);
        reset2();
        pulse_run();
        cyc(4);
        chk("branch_pc", pc_o, 32'h10);
        cyc(4);
        chk("far_pc", pc_o, 32'hffffffff);
        cyc(4);
        chk("wrap_pc", pc_o, 32'd0);
        chk("wrap_instret", instret_o, 32'd3);

        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 32; i++) begin
                int r;
                r = int'($urandom_range(0, 15));
                imem[i] = r < 6  ? mk(6'd1, 5'($urandom), 16'($urandom)) :
                          r < 8  ? mk(6'(24 + 2 * $urandom_range(0, 2)), 5'd0, 16'($urandom)) :
                          r < 10 ? mk(6'd16, 5'($urandom), 16'($urandom)) :
                          r < 11 ? mk(6'd2, 5'd0, 16'($urandom_range(0, 31))) :
                          r < 12 ? mk(6'd3, 5'd0, 16'd0) :
                          (r < 13 && $urandom_range(0, 3) == 0) ? mk(6'h3f, 5'd0, 16'd0) :
                          mk(6'd5, 5'($urandom), 16'($urandom));
            end
            reset2();
            for (int c = 0; c < 500; c++) begin
                rst    = $urandom_range(0, 199) == 0;
                run_i  = $urandom_range(0, 7) == 0;
                step_i = $urandom_range(0, 7) == 0;
                stop_i = $urandom_range(0, 15) == 0;
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
